// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory, execute redirect and decode.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline.
interface fetch_unit_if #(
  parameter int IMEM_W = 14
);
  logic [IMEM_W-1:0] imem_addr_o;
  logic [31:0]       imem_rdata_i;
  logic              redirect_valid_i;
  logic [31:0]       redirect_pc_i;
  logic              dec_valid_o;
  logic              dec_ready_i;
  logic [31:0]       dec_inst_o;
  logic [31:0]       dec_pc_o;
  logic              dec_fault_o;

  modport master (
    output imem_addr_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_fault_o,
    input  imem_rdata_i, redirect_valid_i, redirect_pc_i, dec_ready_i
  );

  modport slave (
    input  imem_addr_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_fault_o,
    output imem_rdata_i, redirect_valid_i, redirect_pc_i, dec_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads instruction memory combinationally and
// buffers fetched words in a 2-entry queue feeding decode; redirects flush the queue.
module fetch_unit #(
  parameter int          IMEM_W   = 14,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic clk_i,
  input  logic rst_ni,
  fetch_unit_if.master bus
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] q_inst  [2];
  logic [31:0] q_pc    [2];
  logic        q_fault [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        head_valid, misaligned, pop, push;

  assign head_valid = (count != 2'd0);
  assign misaligned = (bus.redirect_pc_i[1:0] != 2'b00);
  assign pop        = head_valid & bus.dec_ready_i;

  // Redirect outranks fetch; a full queue only accepts a new word when the head leaves
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    if (bus.redirect_valid_i) begin
      state_nxt = misaligned ? HALT : RUN;
    end else if (state == RUN && (count != 2'd2 || pop)) begin
      push = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= RUN;
      pc     <= RESET_PC;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (bus.redirect_valid_i) begin
        pc     <= {bus.redirect_pc_i[31:2], 2'b00};
        rd_ptr <= 1'b0;
        wr_ptr <= misaligned;
        count  <= misaligned ? 2'd1 : 2'd0;
      end else begin
        if (push) begin
          pc     <= pc + 32'd4;
          wr_ptr <= ~wr_ptr;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Queue storage is gated by count, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (bus.redirect_valid_i && misaligned) begin
      q_inst[0]  <= NOP;
      q_pc[0]    <= bus.redirect_pc_i;
      q_fault[0] <= 1'b1;
    end else if (push) begin
      q_inst[wr_ptr]  <= bus.imem_rdata_i;
      q_pc[wr_ptr]    <= pc;
      q_fault[wr_ptr] <= 1'b0;
    end
  end

  assign bus.imem_addr_o = {pc[IMEM_W-1:2], 2'b00};
  assign bus.dec_valid_o = head_valid;
  assign bus.dec_inst_o  = head_valid ? q_inst[rd_ptr]  : NOP;
  assign bus.dec_pc_o    = head_valid ? q_pc[rd_ptr]    : 32'd0;
  assign bus.dec_fault_o = head_valid ? q_fault[rd_ptr] : 1'b0;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap and async reset.
// A second instance starts at 0xFFFFFFFC to exercise PC wrap-around.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk;
  logic rst0_n, rst1_n;
  int   n_checks, n_errors;

  fetch_unit_if #(.IMEM_W(14)) bus0 ();
  fetch_unit_if #(.IMEM_W(14)) bus1 ();

  fetch_unit #(.IMEM_W(14), .RESET_PC(32'h0000_0000)) dut0 (
    .clk_i (clk),
    .rst_ni(rst0_n),
    .bus   (bus0.master)
  );

  fetch_unit #(.IMEM_W(14), .RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk_i (clk),
    .rst_ni(rst1_n),
    .bus   (bus1.master)
  );

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    case (a)
      14'h0000: mem_word = 32'h0000_0013;
      14'h0004: mem_word = 32'h0010_0093;
      14'h0008: mem_word = 32'h0020_0113;
      default:  mem_word = 32'hA500_0000 | {18'd0, a};
    endcase
  endfunction

  assign bus0.imem_rdata_i = mem_word(bus0.imem_addr_o);
  assign bus1.imem_rdata_i = mem_word(bus1.imem_addr_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, "_valid"}, 32'(bus0.dec_valid_o), 32'd1);
    check({tag, "_pc"},    bus0.dec_pc_o, exp_pc);
    check({tag, "_inst"},  bus0.dec_inst_o, mem_word(exp_pc[13:0]));
    check({tag, "_fault"}, 32'(bus0.dec_fault_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.dec_ready_i = 1'b1;
    bus0.redirect_valid_i = 1'b0;
    bus0.redirect_pc_i = 32'd0;
    bus1.dec_ready_i = 1'b1;
    bus1.redirect_valid_i = 1'b0;
    bus1.redirect_pc_i = 32'd0;
    #1;
    check("rst_valid", 32'(bus0.dec_valid_o), 32'd0);
    check("rst_inst",  bus0.dec_inst_o, NOP);
    check("rst_pc",    bus0.dec_pc_o, 32'd0);
    check("rst_fault", 32'(bus0.dec_fault_o), 32'd0);
    check("rst_addr",  32'(bus0.imem_addr_o), 32'd0);
    tick();
    tick();
    check("rst_hold_valid", 32'(bus0.dec_valid_o), 32'd0);

    // Streaming with ready held high: no bubbles
    rst0_n = 1'b1;
    tick();
    check_head("s0", 32'h0);
    tick();
    check_head("s1", 32'h4);
    tick();
    check_head("s2", 32'h8);

    // Fresh start, then backpressure after the first valid
    rst0_n = 1'b0;
    #1;
    rst0_n = 1'b1;
    tick();
    check_head("b0", 32'h0);
    bus0.dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall_addr", 32'(bus0.imem_addr_o), 32'h8);
      check("stall_pc",   bus0.dec_pc_o, 32'h0);
      check("stall_valid", 32'(bus0.dec_valid_o), 32'd1);
    end
    bus0.dec_ready_i = 1'b1;
    tick();
    check_head("r1", 32'h4);
    tick();
    check_head("r2", 32'h8);
    tick();
    check_head("r3", 32'hC);

    // Redirect to 0x100 with queue full and decode ready
    bus0.redirect_valid_i = 1'b1;
    bus0.redirect_pc_i = 32'h0000_0100;
    tick();
    bus0.redirect_valid_i = 1'b0;
    check("redir_valid", 32'(bus0.dec_valid_o), 32'd0);
    check("redir_addr",  32'(bus0.imem_addr_o), 32'h100);
    tick();
    check_head("t0", 32'h100);
    tick();
    check_head("t1", 32'h104);

    // Misaligned redirect produces a single fault entry then halts fetch
    bus0.redirect_valid_i = 1'b1;
    bus0.redirect_pc_i = 32'h0000_0202;
    tick();
    bus0.redirect_valid_i = 1'b0;
    check("flt_valid", 32'(bus0.dec_valid_o), 32'd1);
    check("flt_fault", 32'(bus0.dec_fault_o), 32'd1);
    check("flt_pc",    bus0.dec_pc_o, 32'h202);
    check("flt_inst",  bus0.dec_inst_o, NOP);
    check("flt_addr",  32'(bus0.imem_addr_o), 32'h200);
    tick();
    check("halt_valid0", 32'(bus0.dec_valid_o), 32'd0);
    tick();
    check("halt_valid1", 32'(bus0.dec_valid_o), 32'd0);
    check("halt_addr",   32'(bus0.imem_addr_o), 32'h200);
    bus0.redirect_valid_i = 1'b1;
    bus0.redirect_pc_i = 32'h0000_0300;
    tick();
    bus0.redirect_valid_i = 1'b0;
    check("resume_valid", 32'(bus0.dec_valid_o), 32'd0);
    check("resume_addr",  32'(bus0.imem_addr_o), 32'h300);
    tick();
    check_head("u0", 32'h300);

    // Fill the queue, then async reset between edges
    bus0.dec_ready_i = 1'b0;
    tick();
    check("full_addr", 32'(bus0.imem_addr_o), 32'h308);
    #2;
    rst0_n = 1'b0;
    #1;
    check("async_valid", 32'(bus0.dec_valid_o), 32'd0);
    check("async_inst",  bus0.dec_inst_o, NOP);
    check("async_addr",  32'(bus0.imem_addr_o), 32'h0);
    #1;
    rst0_n = 1'b1;
    bus0.dec_ready_i = 1'b1;
    tick();
    check_head("a0", 32'h0);

    // PC wrap on the second instance
    rst1_n = 1'b1;
    #1;
    check("wrap_addr0", 32'(bus1.imem_addr_o), 32'h3FFC);
    tick();
    check("wrap_pc0",   bus1.dec_pc_o, 32'hFFFF_FFFC);
    check("wrap_inst0", bus1.dec_inst_o, mem_word(14'h3FFC));
    check("wrap_addr1", 32'(bus1.imem_addr_o), 32'h0);
    tick();
    check("wrap_pc1",   bus1.dec_pc_o, 32'h0);
    check("wrap_inst1", bus1.dec_inst_o, 32'h0000_0013);
    check("wrap_valid", 32'(bus1.dec_valid_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage placed directly upstream of the instruction memory. It owns the program counter, drives the memory's combinational read address, and captures each returned word with its PC into a 2-entry fetch queue. The queue feeds decode over a valid/ready handshake. Branch/jump redirects from execute flush the queue, and misaligned redirect targets are reported as a fetch fault.

## Interface
- IMEM_W, 14, byte-address width of instruction memory (word index = address[IMEM_W-1:2])
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned
- clk_i  in  1  clock; all state updates on rising edge
- rst_ni  in  1  reset; asynchronous, active-low
- imem_addr_o  out  IMEM_W  byte address to instruction memory; equals pc[IMEM_W-1:0], bits [1:0] always 0
- imem_rdata_i  in  32  instruction word; combinational from imem_addr_o, valid in the same cycle
- redirect_valid_i  in  1  redirect request from execute
- redirect_pc_i  in  32  redirect target PC
- dec_valid_o  out  1  queue head valid
- dec_ready_i  in  1  decode accepts head this cycle
- dec_inst_o  out  32  head instruction; 32'h0000_0013 (NOP) when queue empty
- dec_pc_o  out  32  head PC; 0 when queue empty
- dec_fault_o  out  1  head is a misaligned-target fault entry; dec_inst_o = NOP for such entries

## Operation
- State: pc (32 b), 2-entry queue {inst, pc, fault} with rd/wr pointers and count 0..2, FSM {RUN, HALT}.
- Reset (async, rst_ni=0): pc=RESET_PC, count=0, FSM=RUN, dec_valid_o=0, dec_inst_o=NOP, dec_pc_o=0, dec_fault_o=0.
- pop = dec_valid_o & dec_ready_i.
- push = FSM==RUN & !redirect_valid_i & (count<2 | pop). On push, enqueue {imem_rdata_i, pc, 0} and set pc <= pc+4.
- pc wraps modulo 2^32. Memory aliases on the low IMEM_W bits, and the block takes no action on aliasing.
- Full (count==2, no pop): no push, pc holds, imem_addr_o holds.
- Full with pop: push and pop occur in the same cycle, and count stays 2.
- Empty: dec_valid_o=0, and dec_inst_o/dec_pc_o/dec_fault_o show NOP/0/0.
- Redirect (redirect_valid_i=1) has priority over everything. The queue is flushed (count=0) and no push occurs that cycle.
  - Aligned target (redirect_pc_i[1:0]==0): pc <= redirect_pc_i, FSM=RUN.
  - Misaligned target: enqueue a single entry {NOP, redirect_pc_i, fault=1} into the flushed queue, FSM=HALT, and pc <= {redirect_pc_i[31:2],2'b00}.
  - A pop asserted in the redirect cycle still counts as a completed transfer. Squashing the transferred instruction is decode's responsibility.
- HALT: no pushes. The fault entry drains normally. Only an aligned redirect returns FSM to RUN. A misaligned redirect in HALT re-flushes and enqueues a new fault entry.
- pc addition is 32-bit unsigned. Carry out is discarded.

## Timing
- Fetch-to-decode latency is 1 cycle. A word fetched in cycle N (imem_addr_o = PC) appears on dec_* in cycle N+1.
- Sustained throughput is 1 instruction/cycle while dec_ready_i=1.
- Redirect in cycle N:
  - cycle N+1: dec_valid_o=0, imem_addr_o=target.
  - cycle N+2: dec_valid_o=1 with dec_pc_o=target.
- Misaligned redirect in cycle N: the fault entry is visible on dec_* in cycle N+1.
- After rst_ni deasserts: first edge fetches RESET_PC. dec_valid_o rises the cycle after that edge.
- Asynchronous reset mid-operation clears the queue immediately; no partial entry survives.
- Decode handshake rule: while dec_valid_o=1 and dec_ready_i=0, dec_* hold stable, except that a redirect clears them.

## Test plan
- Reset release, memory words 0x00000013/0x00100093/0x00200113 at 0x0/0x4/0x8, dec_ready_i=1 -> dec_pc_o = 0x0, 0x4, 0x8 on consecutive cycles, with matching dec_inst_o and no bubbles.
- dec_ready_i=0 for 4 cycles starting after the first valid -> count saturates at 2 and imem_addr_o holds at 0x8. On release, 0x0, 0x4, 0x8, 0xC are delivered with no loss or duplication.
- redirect_valid_i with target 0x100 while the queue is full and dec_ready_i=1 -> next cycle dec_valid_o=0, imem_addr_o=0x100. The following cycle dec_pc_o=0x100. No entry at or after the old pc is delivered.
- Misaligned redirect to 0x202 -> next cycle dec_valid_o=1, dec_fault_o=1, dec_pc_o=0x202, dec_inst_o=NOP. No further valid entries until an aligned redirect to 0x300, after which dec_pc_o=0x300.
- RESET_PC=32'hFFFF_FFFC, IMEM_W=14 -> fetch at imem_addr_o=0x3FFC, then 0x0000. dec_pc_o goes 0xFFFFFFFC then 0x00000000.
- rst_ni pulsed low asynchronously mid-stream with the queue full -> dec_valid_o drops to 0 without waiting for a clock edge. The first valid after release has dec_pc_o=RESET_PC.
